regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive cycles port B may lose arbitration before it is forced to win.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 a_valid  input  1  port A (single-cycle ALU writeback) request.
REQ-005 a_addr  input  5  port A destination register.
REQ-006 a_data  input  32  port A write data.
REQ-007 a_ready  output  1  port A accepted this cycle.
REQ-008 b_valid, b_addr, b_data, b_ready  as A, widths 1/5/32/1; port B is the multi-cycle unit writeback.
REQ-009 b_issue  input  1  multi-cycle op issued this cycle; marks b_issue_addr pending.
REQ-010 b_issue_addr  input  5  destination of the issued op.
REQ-011 rd_addr1, rd_addr2  input  5 each  decode-stage source registers for hazard check.
REQ-012 stall  output  1  a source register is pending in the scoreboard.
REQ-013 we  output  1  regfile write enable.
REQ-014 writeaddr  output  5  regfile write address.
REQ-015 writedata  output  32  regfile write data.

Function
REQ-016 Handshake: transfer on X_valid && X_ready; at most one of a_ready/b_ready is high per cycle.
REQ-017 X_ready is combinational from the valids and arbitration state; it is never high while X_valid is low.
REQ-018 Arbitration FSM states: PRIO_A (A wins when both valid) and PRIO_B (B wins when both valid).
REQ-019 A lone valid requester is always granted, in either state.
REQ-020 starve_cnt increments each cycle b_valid is high and B is not granted; it clears on any B grant.
REQ-021 PRIO_A -> PRIO_B when starve_cnt reaches STARVE_LIMIT; PRIO_B -> PRIO_A after one B grant.
REQ-022 Write port is registered: the granted addr/data appear on writeaddr/writedata, with we high, in the cycle after the handshake (latency 1).
REQ-023 A granted write to address 0 completes its handshake but produces we=0.
REQ-024 we is low in every cycle following one with no handshake; writeaddr/writedata hold their last values.
REQ-025 Scoreboard: 32-bit pending vector. b_issue sets bit b_issue_addr; a B handshake clears bit b_addr. Bit 0 is never set.
REQ-026 If issue and B retire hit the same address in the same cycle, set wins.
REQ-027 stall = pending[rd_addr1] | pending[rd_addr2], combinational from registered state; address 0 never stalls.
REQ-028 A handshake to a pending address leaves the pending bit unchanged.

Reset
REQ-029 On rst: we=0, writeaddr=0, writedata=0, pending=0, starve_cnt=0, state=PRIO_A.
REQ-030 A handshake coincident with rst is discarded: no write is issued the next cycle.
REQ-031 A b_issue coincident with rst is discarded.

Structure
REQ-032 Shared package holds the FSM state enum (PRIO_A, PRIO_B), REG_AW=5 and XLEN=32.
REQ-033 One sub-module, wb_scoreboard, holds the pending vector, its set/clear logic and the stall lookup; the arbiter instantiates it.
REQ-034 Integration: writeaddr/writedata/we connect directly to the regfile write port. Forwarding of same-cycle writes is the regfile's job, not this block's.

Verification
REQ-035 A only: a_valid=1, a_addr=5, a_data=0xDEADBEEF -> a_ready=1 same cycle; next cycle we=1, writeaddr=5, writedata=0xDEADBEEF.
REQ-036 Contention: A and B valid continuously, STARVE_LIMIT=3 -> grants A,A,A,B,A,A,A,B...; b_ready is never low for more than 3 consecutive cycles.
REQ-037 Scoreboard: b_issue with addr 7 -> stall=1 for rd_addr1=7. B retires addr 7 -> stall=0 in the following cycle. Same-cycle issue and retire of 7 -> stall stays 1.
REQ-038 Zero register: A writes addr 0 -> a_ready=1, next cycle we=0. b_issue with addr 0 -> stall stays 0.
REQ-039 Reset mid-operation: pending={3,9}, state=PRIO_B, rst held one cycle with a_valid=1 -> next cycle we=0, stall=0 for rd_addr 3/9, state=PRIO_A.
REQ-040 Random stimulus with a shadow register model: no handshake is lost or duplicated, and we-write order matches grant order.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   REG_AW / XLEN : register address width and data width
//   NREGS         : number of architectural registers
//   arb_state_t   : arbitration priority state
//   reg_onehot()  : one-hot decode of a register address
package regfile_wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;
  localparam int NREGS  = 1 << REG_AW;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } arb_state_t;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
    return {{(NREGS-1){1'b0}}, 1'b1} << addr;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard for multi-cycle ops.
// A bit is set when a multi-cycle op is issued to that destination and cleared
// when port B retires a write to it. Decode-stage sources are looked up against
// the vector to produce stall.
//   clk, rst           : clock, synchronous active-high reset
//   set_en, set_addr   : issue of a multi-cycle op (marks addr pending)
//   clr_en, clr_addr   : port B handshake (retires addr)
//   rd_addr1, rd_addr2 : decode-stage source registers
//   stall              : at least one source register is pending
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic              stall
);

  // Register 0 is hardwired, so its pending bit is kept permanently clear.
  localparam logic [NREGS-1:0] NONZERO_MASK = {{(NREGS-1){1'b1}}, 1'b0};

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  always_comb begin
    set_mask = set_en ? reg_onehot(set_addr) : '0;
    clr_mask = clr_en ? reg_onehot(clr_addr) : '0;
  end

  // Set is applied after clear so a same-cycle issue and retire of one
  // address leaves it pending (the new op's result is still outstanding).
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= ((pending & ~clr_mask) | set_mask) & NONZERO_MASK;
    end
  end

  assign stall = pending[rd_addr1] | pending[rd_addr2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter in front of a single register-file write port.
// Port A is the single-cycle ALU writeback, port B the multi-cycle unit.
// A normally wins contention; B is forced to win after STARVE_LIMIT
// consecutive lost cycles. The write port is registered (latency 1).
//   clk, rst                            : clock, synchronous active-high reset
//   a_valid/a_addr/a_data/a_ready        : port A writeback handshake
//   b_valid/b_addr/b_data/b_ready        : port B writeback handshake
//   b_issue, b_issue_addr                : multi-cycle op issue (scoreboard set)
//   rd_addr1, rd_addr2, stall            : decode hazard lookup
//   we, writeaddr, writedata             : register-file write port
//
// state  | meaning
// PRIO_A | A wins when both valid; B loss streak counted in starve_cnt
// PRIO_B | B has starved STARVE_LIMIT cycles; B wins, then back to PRIO_A
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [REG_AW-1:0] a_addr,
  input  logic [XLEN-1:0]   a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [REG_AW-1:0] b_addr,
  input  logic [XLEN-1:0]   b_data,
  output logic              b_ready,
  input  logic              b_issue,
  input  logic [REG_AW-1:0] b_issue_addr,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic              stall,
  output logic              we,
  output logic [REG_AW-1:0] writeaddr,
  output logic [XLEN-1:0]   writedata
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW:0] LIMIT_W = (CW + 1)'(STARVE_LIMIT);

  arb_state_t  state;
  logic [CW-1:0] starve_cnt;
  logic [CW:0]   cnt_inc;
  logic [CW-1:0] cnt_sat;
  logic          grant_a;
  logic          grant_b;

  // Grant is purely a function of the valids and priority state, so a lone
  // requester always wins and ready never rises without its valid.
  always_comb begin
    grant_b = b_valid && (!a_valid || (state == PRIO_B));
    grant_a = a_valid && !grant_b;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // One extra bit on the increment keeps the limit compare overflow-free;
  // the stored count saturates at the limit.
  always_comb begin
    cnt_inc = {1'b0, starve_cnt} + {{CW{1'b0}}, 1'b1};
    cnt_sat = (cnt_inc >= LIMIT_W) ? LIMIT_W[CW-1:0] : cnt_inc[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PRIO_A;
      starve_cnt <= '0;
      we         <= 1'b0;
      writeaddr  <= '0;
      writedata  <= '0;
    end else begin
      // Writes to register 0 from A still handshake but never reach the file.
      we <= (grant_a && (a_addr != '0)) || grant_b;

      if (grant_a) begin
        writeaddr <= a_addr;
        writedata <= a_data;
      end else if (grant_b) begin
        writeaddr <= b_addr;
        writedata <= b_data;
      end

      if (grant_b) begin
        starve_cnt <= '0;
      end else if (b_valid) begin
        starve_cnt <= cnt_sat;
      end

      case (state)
        PRIO_A: begin
          if (b_valid && !grant_b && (cnt_inc >= LIMIT_W)) begin
            state <= PRIO_B;
          end
        end
        PRIO_B: begin
          if (grant_b) begin
            state <= PRIO_A;
          end
        end
        default: state <= PRIO_A;
      endcase
    end
  end

  wb_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (b_issue),
    .set_addr (b_issue_addr),
    .clr_en   (grant_b),
    .clr_addr (b_addr),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .stall    (stall)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int STARVE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        b_issue;
  logic [4:0]  b_issue_addr;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        stall;
  logic        we;
  logic [4:0]  writeaddr;
  logic [31:0] writedata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .b_issue      (b_issue),
    .b_issue_addr (b_issue_addr),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .stall        (stall),
    .we           (we),
    .writeaddr    (writeaddr),
    .writedata    (writedata)
  );

  // Reference model: B's loss streak, a pending-register set, and the
  // write the regfile should see next cycle.
  int          m_b_lost = 0;
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        exp_ga;
  logic        exp_gb;
  logic        exp_stall;

  function automatic logic [31:0] pend_after(input logic [31:0] cur, input logic retire,
                                             input logic [4:0] raddr, input logic issue,
                                             input logic [4:0] iaddr);
    logic [31:0] p;
    p = cur;
    if (retire) p[raddr] = 1'b0;
    if (issue && iaddr != 5'd0) p[iaddr] = 1'b1;
    return p;
  endfunction

  always_comb begin
    exp_gb    = b_valid && (!a_valid || (m_b_lost >= STARVE_LIMIT));
    exp_ga    = a_valid && !exp_gb;
    exp_stall = m_pend[rd_addr1] || m_pend[rd_addr2];
  end

  always @(posedge clk) begin
    if (rst) begin
      m_b_lost <= 0;
      m_pend   <= '0;
      m_we     <= 1'b0;
      m_waddr  <= '0;
      m_wdata  <= '0;
    end else begin
      m_b_lost <= exp_gb ? 0 : (b_valid ? m_b_lost + 1 : m_b_lost);
      m_we     <= (exp_ga && a_addr != 5'd0) || exp_gb;
      if (exp_ga) begin
        m_waddr <= a_addr;
        m_wdata <= a_data;
      end else if (exp_gb) begin
        m_waddr <= b_addr;
        m_wdata <= b_data;
      end
      m_pend <= pend_after(m_pend, exp_gb, b_addr, b_issue, b_issue_addr);
    end
  end

  task automatic idle();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    b_issue = 1'b0; b_issue_addr = '0;
    rd_addr1 = '0; rd_addr2 = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h1234_5678;
    b_issue = 1'b1; b_issue_addr = 5'd6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    rd_addr1 = 5'd6;
    #1;
    if (we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", we); end
    checks++;
    if (writeaddr !== 5'd0) begin errors++; $display("FAIL reset_writeaddr got=%0d exp=0", writeaddr); end
    checks++;
    if (writedata !== 32'd0) begin errors++; $display("FAIL reset_writedata got=%h exp=0", writedata); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_issue_discarded stall got=%b exp=0", stall); end
    checks++;
  endtask

  task automatic test_a_only();
    @(negedge clk);
    idle();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL a_only_ready got=%b exp=1", a_ready); end
    checks++;
    if (b_ready !== 1'b0) begin errors++; $display("FAIL a_only_b_ready got=%b exp=0", b_ready); end
    checks++;
    @(negedge clk);
    idle();
    #1;
    if (we !== 1'b1 || writeaddr !== 5'd5 || writedata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL a_only_write got we=%b addr=%0d data=%h exp we=1 addr=5 data=deadbeef",
               we, writeaddr, writedata);
    end
    checks++;
    @(negedge clk);
    #1;
    if (we !== 1'b0 || writeaddr !== 5'd5 || writedata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL a_only_hold got we=%b addr=%0d data=%h exp we=0 addr=5 data=deadbeef",
               we, writeaddr, writedata);
    end
    checks++;
  endtask

  task automatic test_contention();
    int run = 0;
    int max_run = 0;
    logic exp_b;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle();
      a_valid = 1'b1; a_addr = 5'(i + 1); a_data = $urandom;
      b_valid = 1'b1; b_addr = 5'(16 + i); b_data = $urandom;
      #1;
      exp_b = ((i % 4) == 3);
      if (b_ready !== exp_b || a_ready !== !exp_b) begin
        errors++;
        $display("FAIL contention_grant cyc=%0d got a=%b b=%b exp a=%b b=%b",
                 i, a_ready, b_ready, !exp_b, exp_b);
      end
      checks++;
      run = b_ready ? 0 : run + 1;
      if (run > max_run) max_run = run;
    end
    @(negedge clk);
    idle();
    if (max_run > STARVE_LIMIT) begin
      errors++;
      $display("FAIL contention_starve got=%0d exp<=%0d", max_run, STARVE_LIMIT);
    end
    checks++;
  endtask

  task automatic test_scoreboard();
    @(negedge clk); idle(); b_issue = 1'b1; b_issue_addr = 5'd7; rd_addr1 = 5'd7;
    #1;
    if (stall !== 1'b0) begin errors++; $display("FAIL sb_issue_same_cycle got=%b exp=0", stall); end
    checks++;
    @(negedge clk); idle(); rd_addr1 = 5'd7;
    #1;
    if (stall !== 1'b1) begin errors++; $display("FAIL sb_pending got=%b exp=1", stall); end
    checks++;
    @(negedge clk); idle(); rd_addr1 = 5'd7; b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hB7B7_0007;
    #1;
    if (b_ready !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL sb_retire_cycle got ready=%b stall=%b exp ready=1 stall=1", b_ready, stall);
    end
    checks++;
    @(negedge clk); idle(); rd_addr1 = 5'd7;
    #1;
    if (stall !== 1'b0) begin errors++; $display("FAIL sb_retired got=%b exp=0", stall); end
    checks++;
    if (we !== 1'b1 || writeaddr !== 5'd7 || writedata !== 32'hB7B7_0007) begin
      errors++; $display("FAIL sb_b_write got we=%b addr=%0d data=%h exp we=1 addr=7 data=b7b70007",
                         we, writeaddr, writedata);
    end
    checks++;
    @(negedge clk); idle(); b_issue = 1'b1; b_issue_addr = 5'd7;
    @(negedge clk); idle(); rd_addr1 = 5'd7;
    b_issue = 1'b1; b_issue_addr = 5'd7; b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h7;
    #1;
    if (stall !== 1'b1) begin errors++; $display("FAIL sb_reissue got=%b exp=1", stall); end
    checks++;
    @(negedge clk); idle(); rd_addr1 = 5'd7;
    #1;
    if (stall !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%b exp=1", stall); end
    checks++;
    @(negedge clk); idle(); b_valid = 1'b1; b_addr = 5'd7; b_issue = 1'b1; b_issue_addr = 5'd9;
    @(negedge clk); idle(); a_valid = 1'b1; a_addr = 5'd9; a_data = 32'hA9; rd_addr1 = 5'd7; rd_addr2 = 5'd9;
    #1;
    if (stall !== 1'b1 || a_ready !== 1'b1) begin
      errors++; $display("FAIL sb_a_to_pending got stall=%b ready=%b exp 1 1", stall, a_ready);
    end
    checks++;
    @(negedge clk); idle(); rd_addr2 = 5'd9;
    #1;
    if (stall !== 1'b1) begin errors++; $display("FAIL sb_a_keeps_pending got=%b exp=1", stall); end
    checks++;
    @(negedge clk); idle(); b_valid = 1'b1; b_addr = 5'd9;
    @(negedge clk); idle(); rd_addr1 = 5'd7; rd_addr2 = 5'd9;
    #1;
    if (stall !== 1'b0) begin errors++; $display("FAIL sb_all_clear got=%b exp=0", stall); end
    checks++;
  endtask

  task automatic test_zero_reg();
    @(negedge clk); idle(); a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
    #1;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL zero_a_ready got=%b exp=1", a_ready); end
    checks++;
    @(negedge clk); idle(); b_issue = 1'b1; b_issue_addr = 5'd0;
    #1;
    if (we !== 1'b0) begin errors++; $display("FAIL zero_we got=%b exp=0", we); end
    checks++;
    @(negedge clk); idle(); rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    #1;
    if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got=%b exp=0", stall); end
    checks++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle(); b_issue = 1'b1; b_issue_addr = 5'd3;
    @(negedge clk); idle(); b_issue = 1'b1; b_issue_addr = 5'd9;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      @(negedge clk); idle();
      a_valid = 1'b1; a_addr = 5'(10 + i); a_data = $urandom;
      b_valid = 1'b1; b_addr = 5'd20; b_data = $urandom;
    end
    @(negedge clk); idle();
    rst = 1'b1;
    a_valid = 1'b1; a_addr = 5'd11; a_data = 32'h5555_AAAA;
    b_valid = 1'b1; b_addr = 5'd20;
    b_issue = 1'b1; b_issue_addr = 5'd12;
    rd_addr1 = 5'd3; rd_addr2 = 5'd9;
    #1;
    if (b_ready !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL rstmid_precond got b_ready=%b stall=%b exp 1 1", b_ready, stall);
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    idle();
    a_valid = 1'b1; a_addr = 5'd13; b_valid = 1'b1; b_addr = 5'd21;
    rd_addr1 = 5'd3; rd_addr2 = 5'd9;
    #1;
    if (we !== 1'b0) begin errors++; $display("FAIL rstmid_we got=%b exp=0", we); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b exp=0", stall); end
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_prio got a=%b b=%b exp a=1 b=0", a_ready, b_ready);
    end
    checks++;
    @(negedge clk); idle(); rd_addr1 = 5'd12;
    #1;
    if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_issue_discard got=%b exp=0", stall); end
    checks++;
  endtask

  task automatic test_random();
    int exp_writes = 0;
    int obs_writes = 0;
    @(negedge clk); idle(); rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      a_valid      = ($urandom_range(0, 99) < 60);
      a_addr       = 5'($urandom_range(0, 31));
      a_data       = $urandom;
      b_valid      = ($urandom_range(0, 99) < 55);
      b_addr       = 5'($urandom_range(1, 31));
      b_data       = $urandom;
      b_issue      = ($urandom_range(0, 99) < 25);
      b_issue_addr = 5'($urandom_range(0, 31));
      rd_addr1     = 5'($urandom_range(0, 31));
      rd_addr2     = 5'($urandom_range(0, 31));
      rst          = ($urandom_range(0, 149) == 0);
      #1;
      if (a_ready !== exp_ga) begin errors++; $display("FAIL rand_a_ready cyc=%0d got=%b exp=%b", i, a_ready, exp_ga); end
      checks++;
      if (b_ready !== exp_gb) begin errors++; $display("FAIL rand_b_ready cyc=%0d got=%b exp=%b", i, b_ready, exp_gb); end
      checks++;
      if (stall !== exp_stall) begin errors++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", i, stall, exp_stall); end
      checks++;
      if (we !== m_we) begin errors++; $display("FAIL rand_we cyc=%0d got=%b exp=%b", i, we, m_we); end
      checks++;
      if (writeaddr !== m_waddr || writedata !== m_wdata) begin
        errors++;
        $display("FAIL rand_write cyc=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                 i, writeaddr, writedata, m_waddr, m_wdata);
      end
      checks++;
      if (we === 1'b1) obs_writes++;
      if (!rst && ((exp_ga && a_addr != 5'd0) || exp_gb)) exp_writes++;
    end
    @(negedge clk); idle(); rst = 1'b0;
    #1;
    if (we === 1'b1) obs_writes++;
    if (obs_writes != exp_writes) begin
      errors++; $display("FAIL rand_write_count got=%0d exp=%0d", obs_writes, exp_writes);
    end
    checks++;
  endtask

  initial begin
    idle();
    test_reset();
    test_a_only();
    test_contention();
    test_scoreboard();
    test_zero_reg();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
